// File: rtl/bkf_pkg.sv
// Shared definitions for the backpressure-config applier: FSM states,
// status word bit positions and the default reserved clear index.
package bkf_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_BAD     = 3;
    localparam int ST_TMO     = 4;
    localparam int ST_LVL_LSB = 8;
    localparam int ST_CNT_LSB = 16;

    localparam logic [31:0] DEF_CLR_INDEX = 32'hFFFF_FFFF;

endpackage

// File: rtl/bkf_sync_fifo.sv
// Single-clock FIFO with a register-array store; head always shows the
// oldest entry so a pop and its data capture happen on the same edge.
module bkf_sync_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/bkf_cfg_applier.sv
// Turns the forwarder's config strobe into queued, acked writes to the
// config table and reports progress/errors through a registered status word.
module bkf_cfg_applier
    import bkf_pkg::*;
#(
    parameter int          DEPTH       = 8,
    parameter int          ADDR_W      = 8,
    parameter int          NUM_ENTRIES = 256,
    parameter int          ACK_TIMEOUT = 255,
    parameter logic [31:0] CLR_INDEX   = DEF_CLR_INDEX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bkf_ready,
    input  logic [31:0]       bkf_index,
    input  logic [31:0]       bkf_data,
    output logic [31:0]       bk_status_o,
    output logic              cfg_wr_en,
    output logic [ADDR_W-1:0] cfg_wr_addr,
    output logic [31:0]       cfg_wr_data,
    input  logic              cfg_wr_ack
);

    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam int          FW       = ADDR_W + 32;
    localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          rdy_q;
    logic          evt, is_clr, is_bad, want_push, ovf_set, push;
    logic          pop, wr_done, tmo_hit, timer_done;
    logic [FW-1:0] head;
    logic [CW-1:0] level;
    logic          full, empty;
    logic [15:0]   timer_q;
    logic [15:0]   applied_cnt;
    logic          ovf_q, bad_q, tmo_q;
    logic [31:0]   status_d;

    assign evt       = bkf_ready & ~rdy_q;
    assign is_clr    = evt & (bkf_index == CLR_INDEX);
    assign is_bad    = evt & ~is_clr & (bkf_index >= 32'(NUM_ENTRIES));
    assign want_push = evt & ~is_clr & ~is_bad;
    assign ovf_set   = want_push & full & ~pop;
    assign push      = want_push & ~ovf_set;

    bkf_sync_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({bkf_index[ADDR_W-1:0], bkf_data}),
        .pop       (pop),
        .head      (head),
        .count     (level),
        .full      (full),
        .empty     (empty)
    );

    assign timer_done = (timer_q == TMO_LAST);
    assign cfg_wr_en  = (state_q == WRITE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = WRITE;
            WRITE:   if (cfg_wr_ack || timer_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ack beats the timeout when both land in the same cycle.
    always_comb begin
        pop     = (state_q == IDLE) & ~empty;
        wr_done = (state_q == WRITE) & cfg_wr_ack;
        tmo_hit = (state_q == WRITE) & ~cfg_wr_ack & timer_done;
    end

    always_comb begin
        status_d                       = '0;
        status_d[ST_BUSY]              = (state_q != IDLE) | ~empty;
        status_d[ST_FULL]              = full;
        status_d[ST_OVF]               = ovf_q;
        status_d[ST_BAD]               = bad_q;
        status_d[ST_TMO]               = tmo_q;
        status_d[ST_LVL_LSB +: 8]      = 8'(level);
        status_d[ST_CNT_LSB +: 16]     = applied_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q       <= 1'b0;
            cfg_wr_addr <= '0;
            cfg_wr_data <= '0;
            timer_q     <= '0;
            applied_cnt <= '0;
            ovf_q       <= 1'b0;
            bad_q       <= 1'b0;
            tmo_q       <= 1'b0;
            bk_status_o <= '0;
        end else begin
            rdy_q <= bkf_ready;
            if (pop) begin
                cfg_wr_addr <= head[FW-1:32];
                cfg_wr_data <= head[31:0];
                timer_q     <= '0;
            end else if (state_q == WRITE) begin
                if (cfg_wr_ack || timer_done) timer_q <= '0;
                else                          timer_q <= timer_q + 1'b1;
            end
            if (wr_done) applied_cnt <= applied_cnt + 1'b1;
            // Set beats clear on the same edge.
            ovf_q       <= ovf_set | (ovf_q & ~is_clr);
            bad_q       <= is_bad  | (bad_q & ~is_clr);
            tmo_q       <= tmo_hit | (tmo_q & ~is_clr);
            bk_status_o <= status_d;
        end
    end

endmodule

// File: tb/tb_bkf_cfg_applier.sv
// Directed bench for bkf_cfg_applier with DEPTH=4, NUM_ENTRIES=200,
// ACK_TIMEOUT=32; a negedge responder drives acks and logs handshakes.
module tb_bkf_cfg_applier;

    localparam int          DEPTH       = 4;
    localparam int          ADDR_W      = 8;
    localparam int          NUM_ENTRIES = 200;
    localparam int          ACK_TIMEOUT = 32;
    localparam logic [31:0] CLR         = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              bkf_ready = 1'b0;
    logic [31:0]       bkf_index = '0;
    logic [31:0]       bkf_data = '0;
    logic [31:0]       bk_status_o;
    logic              cfg_wr_en;
    logic [ADDR_W-1:0] cfg_wr_addr;
    logic [31:0]       cfg_wr_data;
    logic              cfg_wr_ack = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int ack_mode = 0;
    int en_cycles = 0;
    int en_pulses = 0;
    logic en_prev = 1'b0;
    logic [39:0] exp_q[$];
    logic [39:0] got_q[$];
    int exp_cnt = 0;

    bkf_cfg_applier #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_ENTRIES(NUM_ENTRIES),
        .ACK_TIMEOUT(ACK_TIMEOUT), .CLR_INDEX(CLR)
    ) dut (
        .clk(clk), .rst(rst), .bkf_ready(bkf_ready), .bkf_index(bkf_index),
        .bkf_data(bkf_data), .bk_status_o(bk_status_o), .cfg_wr_en(cfg_wr_en),
        .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data), .cfg_wr_ack(cfg_wr_ack)
    );

    always #5 clk = ~clk;

    // Table-side responder: 0 = never ack, 1 = ack at once, 2 = random ack.
    initial begin
        forever begin
            @(negedge clk);
            case (ack_mode)
                1:       cfg_wr_ack = cfg_wr_en;
                2:       cfg_wr_ack = cfg_wr_en & ($urandom_range(0, 3) != 0);
                default: cfg_wr_ack = 1'b0;
            endcase
            if (!rst && cfg_wr_en && cfg_wr_ack) got_q.push_back({cfg_wr_addr, cfg_wr_data});
            if (cfg_wr_en) en_cycles++;
            if (cfg_wr_en && !en_prev) en_pulses++;
            en_prev = cfg_wr_en;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [31:0] idx, input logic [31:0] data);
        bkf_index = idx;
        bkf_data  = data;
        bkf_ready = 1'b1;
        cycle(1);
        bkf_ready = 1'b0;
        cycle(1);
    endtask

    task automatic wait_idle(input string tag);
        cycle(2);
        for (int i = 0; i < 400 && (bk_status_o[0] || cfg_wr_en); i++) cycle(1);
        check(tag, {62'd0, bk_status_o[0], cfg_wr_en}, 64'd0);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_n"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int pulses_before;
        logic [31:0] idx, dat;

        // Reset state
        cycle(3);
        check("rst_status", 64'(bk_status_o), 64'd0);
        check("rst_en", 64'(cfg_wr_en), 64'd0);
        check("rst_addr_data", {24'd0, cfg_wr_addr, cfg_wr_data}, 64'd0);
        rst = 1'b0;
        cycle(1);

        // 1: single write acked one cycle after cfg_wr_en rises
        ack_mode = 1;
        strobe(32'd5, 32'hA5A5_0001);
        exp_q.push_back({8'd5, 32'hA5A5_0001});
        wait_idle("t1_idle");
        exp_cnt = 1;
        check_writes("t1_wr");
        check("t1_cnt", 64'(bk_status_o[31:16]), 64'(exp_cnt));
        check("t1_pulses", 64'(en_pulses), 64'd1);

        // 2: level held high makes one event
        bkf_index = 32'd7;
        bkf_data  = 32'h0000_0777;
        bkf_ready = 1'b1;
        cycle(20);
        bkf_ready = 1'b0;
        exp_q.push_back({8'd7, 32'h0000_0777});
        wait_idle("t2_idle");
        exp_cnt++;
        check_writes("t2_wr");
        check("t2_cnt", 64'(bk_status_o[31:16]), 64'(exp_cnt));

        // 3: fill with ack held low, then drain
        ack_mode = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            strobe(32'(10 + i), 32'h3000 + 32'(i));
            if (i <= DEPTH) exp_q.push_back({8'(10 + i), 32'h3000 + 32'(i)});
        end
        check("t3_full", 64'(bk_status_o[1]), 64'd1);
        check("t3_ovf", 64'(bk_status_o[2]), 64'd1);
        check("t3_level", 64'(bk_status_o[15:8]), 64'(DEPTH));
        check("t3_no_wr", 64'(got_q.size()), 64'd0);
        ack_mode = 1;
        wait_idle("t3_idle");
        exp_cnt += DEPTH + 1;
        check_writes("t3_wr");
        check("t3_cnt", 64'(bk_status_o[31:16]), 64'(exp_cnt));
        check("t3_not_full", 64'(bk_status_o[1]), 64'd0);

        // 4: out-of-range index, then the reserved clear index
        pulses_before = en_pulses;
        strobe(32'(NUM_ENTRIES), 32'hBAD0_0000);
        check("t4_bad", 64'(bk_status_o[3]), 64'd1);
        strobe(CLR, 32'h0);
        check("t4_clr_bad", 64'(bk_status_o[3]), 64'd0);
        check("t4_clr_ovf", 64'(bk_status_o[2]), 64'd0);
        cycle(3);
        check("t4_no_wr", 64'(en_pulses - pulses_before), 64'd0);
        check("t4_cnt", 64'(bk_status_o[31:16]), 64'(exp_cnt));

        // 5: ack never comes; the write is abandoned after ACK_TIMEOUT cycles
        ack_mode = 0;
        en_cycles = 0;
        strobe(32'd20, 32'h5555_0020);
        strobe(32'd21, 32'h5555_0021);
        for (int i = 0; i < 60 && cfg_wr_en; i++) cycle(1);
        check("t5_en_dropped", 64'(cfg_wr_en), 64'd0);
        check("t5_en_cycles", 64'(en_cycles), 64'(ACK_TIMEOUT));
        ack_mode = 1;
        cycle(1);
        check("t5_tmo", 64'(bk_status_o[4]), 64'd1);
        check("t5_cnt_same", 64'(bk_status_o[31:16]), 64'(exp_cnt));
        exp_q.push_back({8'd21, 32'h5555_0021});
        wait_idle("t5_idle");
        exp_cnt++;
        check_writes("t5_wr");
        check("t5_cnt", 64'(bk_status_o[31:16]), 64'(exp_cnt));

        // 6: reset in the middle of a write with three entries queued
        ack_mode = 0;
        for (int i = 0; i < 4; i++) strobe(32'(30 + i), 32'h6000 + 32'(i));
        check("t6_en", 64'(cfg_wr_en), 64'd1);
        check("t6_level", 64'(bk_status_o[15:8]), 64'd3);
        pulses_before = en_pulses;
        rst = 1'b1;
        cycle(1);
        check("t6_en_rst", 64'(cfg_wr_en), 64'd0);
        check("t6_status_rst", 64'(bk_status_o), 64'd0);
        rst = 1'b0;
        ack_mode = 1;
        cycle(10);
        check("t6_no_wr", 64'(got_q.size()), 64'd0);
        check("t6_no_pulse", 64'(en_pulses - pulses_before), 64'd0);
        check("t6_status", 64'(bk_status_o), 64'd0);
        got_q.delete();
        exp_cnt = 0;

        // Random strobes and acks, paced to stay clear of overflow
        ack_mode = 2;
        for (int i = 0; i < 30; i++) begin
            idx = 32'($urandom_range(0, NUM_ENTRIES - 1));
            dat = $urandom;
            strobe(idx, dat);
            exp_q.push_back({idx[7:0], dat});
            cycle($urandom_range(2, 4));
        end
        wait_idle("rnd_idle");
        exp_cnt = 30;
        check_writes("rnd_wr");
        check("rnd_cnt", 64'(bk_status_o[31:16]), 64'(exp_cnt));
        check("rnd_sticky", 64'(bk_status_o[4:2]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
